// File: rtl/fifo_control.sv
// fifo_control: pointer and flag controller for a 2^ADDR_WIDTH-entry FIFO memory.
//
// Accepts push/pop requests and drives the memory write/read addresses and
// write enable. Occupancy and the full/empty/almost flags come from registered
// state. data_valid_o strobes MEM_RD_LAT cycles after each accepted pop, in line
// with the memory's registered read data.
//
// Ports:
//   clk_i              system clock, rising edge
//   reset_i            synchronous active-high reset
//   push_i / pop_i     write / read requests
//   almost_full_th_i   almost-full threshold, latched in the INIT cycle
//   almost_empty_th_i  almost-empty threshold, latched in the INIT cycle
//   wr_ptr_o/rd_ptr_o  memory write / read addresses
//   mem_wr_en_o        memory write enable (accepted push, combinational)
//   data_valid_o       memory read data valid
//   fifo_count_o       occupancy, 0..DEPTH
//   full_o, empty_o, almost_full_o, almost_empty_o  status flags
//   high_water_o       peak occupancy since reset (FIFO_CTRL_WATERMARK_EN only)
//   error_o            sticky overflow/underflow; cleared only by reset
//
// Build option: define FIFO_CTRL_WATERMARK_EN to add the high_water_o output.

module fifo_control #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_RD_LAT = 1  // 1 or 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [ADDR_WIDTH-1:0] almost_full_th_i,
    input  logic [ADDR_WIDTH-1:0] almost_empty_th_i,
    output logic [ADDR_WIDTH-1:0] wr_ptr_o,
    output logic [ADDR_WIDTH-1:0] rd_ptr_o,
    output logic                  mem_wr_en_o,
    output logic                  data_valid_o,
    output logic [ADDR_WIDTH:0]   fifo_count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
`ifdef FIFO_CTRL_WATERMARK_EN
    output logic [ADDR_WIDTH:0]   high_water_o,
`endif
    output logic                  error_o
);

    localparam logic [ADDR_WIDTH:0]   DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CntOne   = 1;
    localparam logic [ADDR_WIDTH-1:0] PtrOne   = 1;

    typedef enum logic [1:0] {StInit, StIdle, StActive, StError} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   af_th_q, af_th_d;
    logic [ADDR_WIDTH-1:0]   ae_th_q, ae_th_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [MEM_RD_LAT-1:0]   vld_q, vld_d;
    logic                    push_acc, pop_acc;

    always_comb begin
        state_d  = state_q;
        af_th_d  = af_th_q;
        ae_th_d  = ae_th_q;
        push_acc = 1'b0;
        pop_acc  = 1'b0;

        unique case (state_q)
            StInit: begin
                af_th_d = almost_full_th_i;
                ae_th_d = almost_empty_th_i;
                state_d = StIdle;
            end
            StIdle: begin
                // Count is zero: a pop can never be honoured here; with a
                // simultaneous push the pop is simply dropped.
                if (push_i) begin
                    push_acc = 1'b1;
                    state_d  = StActive;
                end else if (pop_i) begin
                    state_d = StError;
                end
            end
            StActive: begin
                if (full_o && push_i && !pop_i) begin
                    state_d = StError;
                end else begin
                    // Push+pop at full is legal: the memory reads first.
                    push_acc = push_i;
                    pop_acc  = pop_i;
                    if (pop_i && !push_i && count_q == CntOne) begin
                        state_d = StIdle;
                    end
                end
            end
            StError: state_d = StError;
            default: state_d = StInit;
        endcase

        wr_ptr_d = push_acc ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop_acc  ? rd_ptr_q + PtrOne : rd_ptr_q;

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // Read-valid pipeline: one stage per cycle of memory read latency.
        vld_d    = vld_q;
        vld_d[0] = pop_acc;
        for (int i = 1; i < int'(MEM_RD_LAT); i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StInit;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            // Until INIT latches real thresholds, these hold almost_full low
            // and almost_empty high at zero occupancy.
            af_th_q  <= '1;
            ae_th_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            af_th_q  <= af_th_d;
            ae_th_q  <= ae_th_d;
        end
    end

`ifdef FIFO_CTRL_WATERMARK_EN
    logic [ADDR_WIDTH:0] hw_q, hw_d;

    always_comb begin
        hw_d = hw_q;
        if (state_q != StError && count_q > hw_q) begin
            hw_d = count_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hw_q <= '0;
        end else begin
            hw_q <= hw_d;
        end
    end

    assign high_water_o = hw_q;
`endif

    assign wr_ptr_o       = wr_ptr_q;
    assign rd_ptr_o       = rd_ptr_q;
    // Never write while reset is asserted, whatever state it interrupts.
    assign mem_wr_en_o    = push_acc && !reset_i;
    assign data_valid_o   = vld_q[MEM_RD_LAT-1];
    assign fifo_count_o   = count_q;
    assign full_o         = (count_q == DepthCnt);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= {1'b0, af_th_q});
    assign almost_empty_o = (count_q <= {1'b0, ae_th_q});
    assign error_o        = (state_q == StError);

endmodule

// File: tb/tb_fifo_control.sv
// tb_fifo_control: table-driven check of fifo_control (ADDR_WIDTH=3, MEM_RD_LAT=1,
// almost_full_th=6, almost_empty_th=1). Each table row gives the request for one
// cycle and the outputs expected during that cycle. A small memory behind the
// controller plus a reference queue check the read data flowing out with
// data_valid. Define FIFO_CTRL_WATERMARK_EN to also exercise high_water_o.

module tb_fifo_control;

    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          push_i = 1'b0;
    logic          pop_i = 1'b0;
    logic [AW-1:0] af_th = 3'd6;
    logic [AW-1:0] ae_th = 3'd1;
    logic [AW-1:0] wr_ptr_o, rd_ptr_o;
    logic          mem_wr_en_o, data_valid_o;
    logic [AW:0]   fifo_count_o;
    logic          full_o, empty_o, almost_full_o, almost_empty_o, error_o;
`ifdef FIFO_CTRL_WATERMARK_EN
    logic [AW:0]   high_water_o;
`endif

    fifo_control #(.ADDR_WIDTH(AW), .MEM_RD_LAT(1)) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .push_i            (push_i),
        .pop_i             (pop_i),
        .almost_full_th_i  (af_th),
        .almost_empty_th_i (ae_th),
        .wr_ptr_o          (wr_ptr_o),
        .rd_ptr_o          (rd_ptr_o),
        .mem_wr_en_o       (mem_wr_en_o),
        .data_valid_o      (data_valid_o),
        .fifo_count_o      (fifo_count_o),
        .full_o            (full_o),
        .empty_o           (empty_o),
        .almost_full_o     (almost_full_o),
        .almost_empty_o    (almost_empty_o),
`ifdef FIFO_CTRL_WATERMARK_EN
        .high_water_o      (high_water_o),
`endif
        .error_o           (error_o)
    );

    always #5 clk = ~clk;

    // Read-first registered memory, one cycle read latency.
    logic [7:0] mem [8];
    logic [7:0] din = 8'h00;
    logic [7:0] rd_data;
    always @(posedge clk) begin
        if (mem_wr_en_o) mem[wr_ptr_o] <= din;
        rd_data <= mem[rd_ptr_o];
    end

    typedef struct {
        bit       rst;   // apply reset before this row
        bit       push;
        bit       pop;
        bit       wen;   // expected mem_wr_en
        bit       pa;    // pop expected to be accepted
        int       cnt;
        int       wp;
        int       rp;
        bit       dv;
        bit       full;
        bit       empty;
        bit       af;
        bit       ae;
        bit       err;
    } vec_t;

    vec_t       tv[$];
    logic [7:0] ref_q[$];   // data held in the FIFO
    logic [7:0] sb_q[$];    // data expected on upcoming data_valid strobes
    logic [7:0] data_n = 8'h40;
    int         total = 0;
    int         bad = 0;

    function automatic vec_t mk(bit rst, bit push, bit pop, bit wen, bit pa, int cnt, int wp,
                                int rp, bit dv, bit full, bit empty, bit af, bit ae, bit err);
        vec_t v;
        v.rst = rst; v.push = push; v.pop = pop; v.wen = wen; v.pa = pa;
        v.cnt = cnt; v.wp = wp; v.rp = rp; v.dv = dv; v.full = full;
        v.empty = empty; v.af = af; v.ae = ae; v.err = err;
        return v;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic do_reset();
        reset_i = 1'b1;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        ref_q.delete();
        sb_q.delete();
    endtask

    // Drive one cycle's requests, then sample at the falling edge.
    task automatic drive(input bit p, input bit q);
        push_i = p;
        pop_i  = q;
        din    = data_n;
        @(negedge clk);
        if (data_valid_o) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL read data: got strobe with data %0h want no strobe", rd_data);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                total--;
                chk("read data", rd_data, e);
            end
        end
    endtask

    // Update the reference queues for this cycle and move past the next edge.
    task automatic finish_cyc(input bit exp_wen, input bit exp_pa);
        if (exp_pa && ref_q.size() != 0) sb_q.push_back(ref_q.pop_front());
        if (exp_wen) begin
            ref_q.push_back(data_n);
            data_n = data_n + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // INIT cycle right after reset ignores a push
        tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // 8 pushes to full
        for (int i = 0; i < 8; i++)
            tv.push_back(mk(0, 1, 0, 1, 0, i, i, 0, 0, 0, i == 0, i >= 6, i <= 1, 0));
        // 8 pops to empty
        for (int i = 0; i < 8; i++)
            tv.push_back(mk(0, 0, 1, 0, 1, 8 - i, 0, i, i > 0, i == 0, 0, (8 - i) >= 6,
                            (8 - i) <= 1, 0));
        // refill; first row still sees the final pop's strobe
        for (int i = 0; i < 8; i++)
            tv.push_back(mk(0, 1, 0, 1, 0, i, i, 0, i == 0, 0, i == 0, i >= 6, i <= 1, 0));
        // push+pop at full for 4 cycles
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(0, 1, 1, 1, 1, 8, i, i, i > 0, 1, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 8, 4, 4, 1, 1, 0, 1, 0, 0));
        // overflow, then error state ignores requests
        tv.push_back(mk(0, 1, 0, 0, 0, 8, 4, 4, 0, 1, 0, 1, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 8, 4, 4, 0, 1, 0, 1, 0, 1));
        // reset clears everything; INIT ignores push
        tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // push+pop on empty: push only
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tv.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0));
        // underflow pop in IDLE
        tv.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1));

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            vec_t v;
            v = tv[i];
            if (v.rst) do_reset();
            drive(v.push, v.pop);
            chk($sformatf("r%0d mem_wr_en", i), mem_wr_en_o, v.wen);
            chk($sformatf("r%0d count", i), fifo_count_o, v.cnt);
            chk($sformatf("r%0d wr_ptr", i), wr_ptr_o, v.wp);
            chk($sformatf("r%0d rd_ptr", i), rd_ptr_o, v.rp);
            chk($sformatf("r%0d data_valid", i), data_valid_o, v.dv);
            chk($sformatf("r%0d full", i), full_o, v.full);
            chk($sformatf("r%0d empty", i), empty_o, v.empty);
            chk($sformatf("r%0d almost_full", i), almost_full_o, v.af);
            chk($sformatf("r%0d almost_empty", i), almost_empty_o, v.ae);
            chk($sformatf("r%0d error", i), error_o, v.err);
            finish_cyc(v.wen, v.pa);
        end
        chk("strobes drained", sb_q.size(), 0);

`ifdef FIFO_CTRL_WATERMARK_EN
        do_reset();
        drive(0, 0);
        chk("hw after reset", high_water_o, 0);
        finish_cyc(0, 0);
        repeat (5) begin drive(1, 0); finish_cyc(1, 0); end
        repeat (3) begin drive(0, 1); finish_cyc(0, 1); end
        drive(1, 0);
        finish_cyc(1, 0);
        drive(0, 0);
        chk("hw count", fifo_count_o, 3);
        chk("hw high_water", high_water_o, 5);
        finish_cyc(0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
